quad_encoder_counter: RTL
=========================

// Module: quad_encoder_counter
// PURPOSE
//  Front end for the rotary encoder on the FPGA board. Synchronises and filters the two
//  raw encoder lines, then decodes the quadrature Gray sequence. It keeps a WIDTH-bit
//  up/down position count. COUNT is the 8-bit operand fed to the downstream
//  shift/multiply/divide and BCD display stage. STEP_UP, STEP_DN and DIR feed the
//  direction LEDs.
// PARAMETERS
//  WIDTH       8       width of COUNT
//  SAMPLE_DIV  80_000  CLK cycles between filter samples (1.6 ms at 50 MHz); >=2
//  FILT_LEN    3       consecutive identical samples required to accept a new state; >=1
//  CPC         4       counts per quadrature cycle: 4, 2 or 1
//  SATURATE    0       0 = COUNT wraps modulo 2^WIDTH; 1 = COUNT clamps at 0 and 2^WIDTH-1
// PORTS
//  CLK      in   1      50 MHz system clock
//  RST_N    in   1      asynchronous, active-low reset
//  ENCODER  in   2      raw encoder lines {A,B}, asynchronous to CLK
//  CLR      in   1      synchronous clear of COUNT, active high
//  COUNT    out  WIDTH  position count
//  STEP_UP  out  1      1-cycle pulse on each counted clockwise step
//  STEP_DN  out  1      1-cycle pulse on each counted counter-clockwise step
//  DIR      out  1      direction of the last counted step (1 = CW, 0 = CCW)
//  ERR      out  1      1-cycle pulse on an illegal transition (both bits changed)
// BEHAVIOUR
//  - Reset (RST_N=0, async): COUNT=0, STEP_UP=STEP_DN=ERR=0, DIR=0.
//    Synchroniser=00, divider=0, filter run=0, VALID=0.
//  - Input path: 2-FF synchroniser on ENCODER. The divider raises TICK for 1 cycle
//    every SAMPLE_DIV cycles.
//  - Filter, on TICK: compare the synced value with the previous sample. If equal,
//    run++ (saturating); otherwise run=1. The value is accepted when run reaches
//    FILT_LEN and the value differs from STABLE.
//  - State register STABLE holds one of 00, 01, 11, 10.
//    - CW order: 00->01->11->10->00. CCW is the reverse.
//    - With VALID=0, the first accepted value only loads STABLE and sets VALID=1.
//      It produces no step and no ERR.
//  - On an accepted transition with VALID=1, classify old->new:
//    - CW neighbour: candidate up step.
//    - CCW neighbour: candidate down step.
//    - Both bits changed: ERR pulse, no step, DIR unchanged.
//    - In every case STABLE is then updated to the new value.
//  - Which candidates are counted, per CPC:
//    - CPC=4: every candidate.
//    - CPC=2: only candidates whose new state is 00 or 11.
//    - CPC=1: only candidates whose new state is 00.
//  - A counted step does all of the following on the same CLK edge:
//    - COUNT changes by +/-1.
//    - STEP_UP or STEP_DN is high for exactly that one cycle.
//    - DIR is updated.
//  - Arithmetic:
//    - SATURATE=0: COUNT wraps (2^WIDTH-1 +1 -> 0; 0 -1 -> 2^WIDTH-1).
//    - SATURATE=1: at the limit COUNT holds, but the STEP pulse still fires.
//  - CLR has priority over a step in the same cycle: COUNT=0 and the STEP pulse still
//    fires. CLR does not touch STABLE, VALID or the filter.
//  - At most one step per TICK. STEP_UP and STEP_DN are never high together.
//  - Latency from a stable ENCODER change to the COUNT update:
//    2 (sync) + up to FILT_LEN*SAMPLE_DIV + 1 cycles.
//  - RST_N asserted mid-sequence aborts everything. After release, the first accepted
//    state re-initialises STABLE without counting.
// TESTING (bench uses SAMPLE_DIV=4, FILT_LEN=2, WIDTH=8)
//  1. Reset, hold 00 for 20 cycles, then CW 00->01->11->10->00, each held 12 cycles,
//     CPC=4 -> COUNT=4, four STEP_UP pulses, DIR=1, ERR never high.
//  2. From COUNT=0 with STABLE=00, step 00->10:
//     SATURATE=0 -> COUNT=255, STEP_DN=1 for one cycle, DIR=0.
//     SATURATE=1 -> COUNT stays 0, STEP_DN still pulses.
//  3. Stable 00, then glitch to 01 for one TICK only, then back to 00
//     -> no STEP pulse, COUNT unchanged.
//  4. Stable 00, then jump to 11 and hold -> one ERR pulse, COUNT unchanged.
//     A following 11->10 counts +1 in CPC=4.
//  5. CPC=1, full CW cycle from 00 -> COUNT +1 only on entering 00.
//     CPC=2 -> +2 (on 11 and on 00).
//  6. Assert CLR in the same cycle as a counted STEP_UP -> COUNT=0.
//     Assert RST_N=0 mid-sequence at state 11, release, hold 11 then go to 10
//     -> COUNT=0 and 1 after the 11->10 step.

Source files
------------

// File: rtl/quad_encoder_counter.sv
// Quadrature encoder front end: 2-FF sync, sampled run-length filter, Gray decode, up/down count.
// Latency: 2 sync + up to FILT_LEN*SAMPLE_DIV + 1 cycles from a stable input change to count_o.
// Backpressure: none; a free-running sampler, so at most one step is produced per sample tick.
// Ports:
//   clk_i      system clock
//   rst_ni     asynchronous active-low reset
//   encoder_i  raw {A,B} encoder lines, asynchronous to clk_i
//   clr_i      synchronous clear of count_o (wins over a step in the same cycle)
//   count_o    WIDTH-bit position count
//   step_up_o  1-cycle pulse per counted clockwise step
//   step_dn_o  1-cycle pulse per counted counter-clockwise step
//   dir_o      direction of the last counted step (1 = CW)
//   err_o      1-cycle pulse on an illegal transition (both bits changed)
module quad_encoder_counter #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned SAMPLE_DIV = 80_000,
  parameter int unsigned FILT_LEN   = 3,
  parameter int unsigned CPC        = 4,
  parameter bit          SATURATE   = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [1:0]       encoder_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] count_o,
  output logic             step_up_o,
  output logic             step_dn_o,
  output logic             dir_o,
  output logic             err_o
);

  localparam int unsigned DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned RUN_W = $clog2(FILT_LEN + 1);
  localparam logic [DIV_W-1:0] DIV_MAX   = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [RUN_W-1:0] RUN_MAX   = RUN_W'(FILT_LEN);
  localparam logic [WIDTH-1:0] COUNT_MAX = {WIDTH{1'b1}};

  // Next state in the clockwise Gray order 00->01->11->10->00.
  function automatic logic [1:0] cw_next(input logic [1:0] s);
    case (s)
      2'b00:   cw_next = 2'b01;
      2'b01:   cw_next = 2'b11;
      2'b11:   cw_next = 2'b10;
      default: cw_next = 2'b00;
    endcase
  endfunction

  logic [1:0]       sync1_q, sync2_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       samp_q, samp_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [1:0]       stable_q, stable_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             step_up_q, step_up_d;
  logic             step_dn_q, step_dn_d;
  logic             dir_q, dir_d;
  logic             err_q, err_d;

  logic tick, accept, is_cw, is_ccw, cpc_ok, up_step, dn_step;

  always_comb begin
    tick   = (div_q == DIV_MAX);
    div_d  = tick ? '0 : div_q + DIV_W'(1);

    // Run-length filter: run counts consecutive identical samples, saturating at FILT_LEN.
    samp_d = samp_q;
    run_d  = run_q;
    if (tick) begin
      samp_d = sync2_q;
      if (sync2_q == samp_q) begin
        run_d = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
      end else begin
        run_d = RUN_W'(1);
      end
    end

    // Before the first acceptance any settled value is taken, even if it equals the
    // reset contents of stable_q; afterwards only a genuinely new value is.
    accept = tick && (run_d == RUN_MAX) && (!valid_q || (sync2_q != stable_q));

    is_cw  = (cw_next(stable_q) == sync2_q);
    is_ccw = (cw_next(sync2_q) == stable_q);

    // Coarser resolutions only count steps landing on the chosen detent states.
    if (CPC == 4)      cpc_ok = 1'b1;
    else if (CPC == 2) cpc_ok = (sync2_q == 2'b00) || (sync2_q == 2'b11);
    else               cpc_ok = (sync2_q == 2'b00);

    up_step = accept && valid_q && is_cw && cpc_ok;
    dn_step = accept && valid_q && is_ccw && cpc_ok;
    err_d   = accept && valid_q && !is_cw && !is_ccw;

    stable_d  = accept ? sync2_q : stable_q;
    valid_d   = valid_q | accept;
    step_up_d = up_step;
    step_dn_d = dn_step;

    dir_d = dir_q;
    if (up_step) dir_d = 1'b1;
    if (dn_step) dir_d = 1'b0;

    count_d = count_q;
    if (up_step) begin
      if (!(SATURATE && (count_q == COUNT_MAX))) count_d = count_q + WIDTH'(1);
    end else if (dn_step) begin
      if (!(SATURATE && (count_q == '0))) count_d = count_q - WIDTH'(1);
    end
    if (clr_i) count_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q   <= 2'b00;
      sync2_q   <= 2'b00;
      div_q     <= '0;
      samp_q    <= 2'b00;
      run_q     <= '0;
      stable_q  <= 2'b00;
      valid_q   <= 1'b0;
      count_q   <= '0;
      step_up_q <= 1'b0;
      step_dn_q <= 1'b0;
      dir_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      sync1_q   <= encoder_i;
      sync2_q   <= sync1_q;
      div_q     <= div_d;
      samp_q    <= samp_d;
      run_q     <= run_d;
      stable_q  <= stable_d;
      valid_q   <= valid_d;
      count_q   <= count_d;
      step_up_q <= step_up_d;
      step_dn_q <= step_dn_d;
      dir_q     <= dir_d;
      err_q     <= err_d;
    end
  end

  assign count_o   = count_q;
  assign step_up_o = step_up_q;
  assign step_dn_o = step_dn_q;
  assign dir_o     = dir_q;
  assign err_o     = err_q;

endmodule
